isochronous_4phase_responder: RTL and testbench



---
 rtl/isochronous_hs_pkg.sv | 13 +
 rtl/isochronous_4phase_responder.sv | 91 +++++++++
 tb/tb_isochronous_4phase_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/isochronous_hs_pkg.sv
// Shared definitions for the isochronous 4-phase handshake pair.
// Latency: none (types only).
// Backpressure: n/a.
// Contents: responder FSM state type. The mirrored initiator block reuses it.
package isochronous_hs_pkg;

    // Idle: ack low, waiting for a request. Ack: ack high, waiting for req to fall.
    typedef enum logic {
        Idle = 1'b0,
        Ack  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/isochronous_4phase_responder.sv
// Responder end of a level-based 4-phase req/ack handshake from an isochronous peer,
// presenting captured words downstream as a valid/ready stream via a one-entry buffer.
// Latency: req_i sampled high at edge N -> ack_o and valid_o high after edge N.
// Backpressure: a full, non-draining buffer holds ack_o low, so the peer keeps req_i/data_i.
//
// Ports:
//   clk_i    block clock
//   rst_i    asynchronous active-high reset
//   req_i    4-phase request from peer (level)
//   data_i   peer data, stable while req_i && !ack_o
//   ack_o    4-phase acknowledge to peer (registered)
//   valid_o  downstream valid (buffer full flag, registered)
//   data_o   downstream data (buffer contents, registered)
//   ready_i  downstream ready
module isochronous_4phase_responder
    import isochronous_hs_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ack_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 ready_i
);

    rsp_state_e           r_state;
    logic                 r_ack;
    logic                 r_valid;
    logic [DataWidth-1:0] r_data;

    logic w_drain;
    logic w_can_accept;
    logic w_capture;

    // Peer signals are STA-timed against clk_i, so they are sampled directly.
    assign w_drain      = r_valid && ready_i;
    // A draining buffer counts as empty: the new word replaces it with no bubble.
    assign w_can_accept = !r_valid || ready_i;
    // Capture only on the Idle->Ack transition; a word held in Ack is never re-taken.
    assign w_capture    = (r_state == Idle) && req_i && w_can_accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= Idle;
            r_ack   <= 1'b0;
        end else if (r_state == Idle) begin
            if (w_capture) begin
                r_state <= Ack;
                r_ack   <= 1'b1;
            end
        end else begin
            if (!req_i) begin
                r_state <= Idle;
                r_ack   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign ack_o   = r_ack;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    // Peer must hold data while its request is pending and unacknowledged.
    a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !ack_o) |=> (!req_i || ack_o || $stable(data_i)));

    // A new request may only start once the previous acknowledge has fallen.
    a_no_req_rise_in_ack : assert property (@(posedge clk_i) disable iff (rst_i)
        $rose(req_i) |-> !ack_o);

    // Downstream output is held until it is taken.
    a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> ($stable(valid_o) && $stable(data_o)));

endmodule

// File: tb/tb_isochronous_4phase_responder.sv
module tb_isochronous_4phase_responder;

    localparam int DW = 32;

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b1;
    logic          req_i   = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic          ready_i = 1'b0;
    logic          ack_o;
    logic          valid_o;
    logic [DW-1:0] data_o;

    isochronous_4phase_responder #(.DataWidth(DW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int xfers  = 0;
    bit armed  = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Peer-side view: was the current request already acknowledged, is the
    // buffer holding a word, and which word. Words offered by the peer are
    // queued in exp_q and must leave on valid/ready in the same order.
    bit            m_ack   = 1'b0;
    bit            m_full  = 1'b0;
    logic [DW-1:0] m_word  = '0;
    bit            m_taken;
    bit            m_room;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_ack  = 1'b0;
            m_full = 1'b0;
            m_word = '0;
        end else begin
            m_taken = m_full && ready_i;
            if (valid_o && ready_i) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 32'(valid_o), 32'd0);
                end else begin
                    chk("xfer_data", data_o, exp_q.pop_front());
                end
            end
            m_room = !m_full || m_taken;
            if (m_taken) m_full = 1'b0;
            if (m_ack) begin
                if (!req_i) m_ack = 1'b0;
            end else if (req_i && m_room) begin
                m_ack  = 1'b1;
                m_full = 1'b1;
                m_word = data_i;
            end
        end
    end

    always @(negedge clk_i) begin
        if (armed && !rst_i) begin
            chk("cyc_ack", 32'(ack_o), 32'(m_ack));
            chk("cyc_valid", 32'(valid_o), 32'(m_full));
            if (m_full) chk("cyc_data", data_o, m_word);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        for (int k = 0; k < 20; k++) begin
            if (ack_o == lvl) break;
            tick();
        end
        chk(name, 32'(ack_o), 32'(lvl));
    endtask

    task automatic raise(input logic [DW-1:0] d);
        data_i = d;
        req_i  = 1'b1;
        exp_q.push_back(d);
    endtask

    int last_cap;
    int x0;

    initial begin
        // Reset state
        #2;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", data_o, 32'h0);
        tick();
        tick();
        #3 rst_i = 1'b0;
        armed = 1'b1;
        tick();

        // Single word
        ready_i = 1'b1;
        raise(32'hDEADBEEF);
        tick();
        chk("single_ack", 32'(ack_o), 32'd1);
        chk("single_valid", 32'(valid_o), 32'd1);
        chk("single_data", data_o, 32'hDEADBEEF);
        tick();
        chk("single_valid_e1", 32'(valid_o), 32'd0);
        chk("single_ack_e1", 32'(ack_o), 32'd1);
        req_i = 1'b0;
        tick();
        chk("single_ack_drop", 32'(ack_o), 32'd0);

        // Backpressure
        ready_i = 1'b0;
        raise(32'h1);
        tick();
        chk("bp_w1_ack", 32'(ack_o), 32'd1);
        req_i = 1'b0;
        tick();
        chk("bp_w1_ackdrop", 32'(ack_o), 32'd0);
        raise(32'h2);
        tick();
        chk("bp_w2_held", 32'(ack_o), 32'd0);
        chk("bp_w1_kept", data_o, 32'h1);
        tick();
        chk("bp_w2_held2", 32'(ack_o), 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("bp_w2_ack", 32'(ack_o), 32'd1);
        chk("bp_w2_valid", 32'(valid_o), 32'd1);
        chk("bp_w2_data", data_o, 32'h2);
        req_i = 1'b0;
        tick();
        chk("bp_w2_ackdrop", 32'(ack_o), 32'd0);
        ready_i = 1'b1;
        tick();
        chk("bp_drained", 32'(valid_o), 32'd0);

        // Back-to-back, 8 words at one per 2 cycles
        x0 = xfers;
        last_cap = 0;
        for (int i = 0; i < 8; i++) begin
            raise(DW'(i));
            wait_ack(1'b1, "b2b_ack_up");
            if (i > 0) chk("b2b_interval", 32'(cyc - last_cap), 32'd2);
            last_cap = cyc;
            req_i = 1'b0;
            wait_ack(1'b0, "b2b_ack_down");
        end
        tick();
        chk("b2b_count", 32'(xfers - x0), 32'd8);

        // Slow peer holds req for 10 cycles after ack
        x0 = xfers;
        raise(32'hA5A5A5A5);
        wait_ack(1'b1, "slow_ack_up");
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("slow_ack_hold", 32'(ack_o), 32'd1);
        end
        chk("slow_one_xfer", 32'(xfers - x0), 32'd1);
        req_i = 1'b0;
        #2;
        chk("slow_ack_before_edge", 32'(ack_o), 32'd1);
        tick();
        chk("slow_ack_after_edge", 32'(ack_o), 32'd0);

        // Reset mid-operation, released with req low
        ready_i = 1'b0;
        raise(32'h0000CAFE);
        tick();
        chk("rmid_ack", 32'(ack_o), 32'd1);
        chk("rmid_valid", 32'(valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        req_i = 1'b0;
        exp_q.delete();
        #1;
        chk("rmid_async_ack", 32'(ack_o), 32'd0);
        chk("rmid_async_valid", 32'(valid_o), 32'd0);
        tick();
        #2 rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rmid_idle_valid", 32'(valid_o), 32'd0);
            chk("rmid_idle_ack", 32'(ack_o), 32'd0);
        end

        // Reset while peer keeps req high: word is captured again
        raise(32'h77);
        tick();
        chk("rcap_first", 32'(ack_o), 32'd1);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h77);
        #1;
        chk("rcap_async_ack", 32'(ack_o), 32'd0);
        tick();
        #2 rst_i = 1'b0;
        tick();
        chk("rcap_ack", 32'(ack_o), 32'd1);
        chk("rcap_data", data_o, 32'h77);
        ready_i = 1'b1;
        req_i   = 1'b0;
        tick();
        tick();
        chk("rcap_drained", 32'(valid_o), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
